// File: rtl/seg7_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_pkg                                                            |
// | Shared segment type, glyph constants and digit-count limits.        |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package seg7_pkg;

   // Index 0 = segment a; all patterns are active low.
   typedef logic [0:6] seg7_t;

   localparam seg7_t SEG_BLANK = 7'b1111111;

   localparam seg7_t SEG_0 = 7'b0000001;
   localparam seg7_t SEG_1 = 7'b1001111;
   localparam seg7_t SEG_2 = 7'b0010010;
   localparam seg7_t SEG_3 = 7'b0000110;
   localparam seg7_t SEG_4 = 7'b1001100;
   localparam seg7_t SEG_5 = 7'b0100100;
   localparam seg7_t SEG_6 = 7'b0100000;
   localparam seg7_t SEG_7 = 7'b0001111;
   localparam seg7_t SEG_8 = 7'b0000000;
   localparam seg7_t SEG_9 = 7'b0000100;
   localparam seg7_t SEG_A = 7'b0001000;
   localparam seg7_t SEG_B = 7'b1100000;
   localparam seg7_t SEG_C = 7'b0110001;
   localparam seg7_t SEG_D = 7'b1000010;
   localparam seg7_t SEG_E = 7'b0110000;
   localparam seg7_t SEG_F = 7'b0111000;

   localparam int DIGITS_MIN = 1;
   localparam int DIGITS_MAX = 8;

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_scan_driver_if                                                 |
// | Load port from the datapath plus the display pin group.             |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface seg7_scan_driver_if
   import seg7_pkg::*;
#(
   parameter int DIGITS = 4
);
   logic                  load;
   logic [4*DIGITS-1:0]   value_in;
   logic [DIGITS-1:0]     dp_in;
   logic                  lzb_in;
   seg7_t                 seg;
   logic                  dp_n;
   logic [DIGITS-1:0]     an;

   modport master (
      output load, value_in, dp_in, lzb_in,
      input  seg, dp_n, an
   );

   modport slave (
      input  load, value_in, dp_in, lzb_in,
      output seg, dp_n, an
   );
endinterface
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_decode                                                         |
// | Nibble to active-low a..g; hex glyphs only when SEG7_HEX_EN is set. |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module seg7_decode
   import seg7_pkg::*;
(
   input  wire logic [3:0] nibble,
   output seg7_t           seg,
   output logic            blank
);
   always_comb begin
      seg   = SEG_BLANK;
      blank = 1'b0;
      case (nibble)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
`ifdef SEG7_HEX_EN
         4'd10:   seg = SEG_A;
         4'd11:   seg = SEG_B;
         4'd12:   seg = SEG_C;
         4'd13:   seg = SEG_D;
         4'd14:   seg = SEG_E;
         default: seg = SEG_F;
`else
         // Non-decimal values render dark, decimal point included.
         default: blank = 1'b1;
`endif
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_scan_driver                                                    |
// | Multiplexed common-anode digit scanner with LZ blanking and guard.  |
// | Optional hex glyphs: define SEG7_HEX_EN.                            |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 50000,
   parameter int GUARD    = 16
)(
   input  wire logic         clk,
   input  wire logic         rst_n,
   seg7_scan_driver_if.slave bus
);
   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
   localparam int unsigned      ON_CYCLES = SCAN_DIV - GUARD;

   generate
      if (DIGITS < DIGITS_MIN || DIGITS > DIGITS_MAX) begin : g_bad_digits
         $error("seg7_scan_driver: DIGITS out of range");
      end
      if (SCAN_DIV < 2 || GUARD < 0 || GUARD >= SCAN_DIV) begin : g_bad_timing
         $error("seg7_scan_driver: SCAN_DIV/GUARD out of range");
      end
   endgenerate

   logic [CNT_W-1:0]    cnt;
   logic [IDX_W-1:0]    idx;
   logic [4*DIGITS-1:0] val_q;
   logic [DIGITS-1:0]   dp_q;
   logic                lzb_q;

   logic [DIGITS-1:0]   lz_mask;
   logic                zero_run;
   logic [3:0]          nib;
   logic                dp_cur;
   logic                lz_cur;
   logic                an_on;
   logic [DIGITS-1:0]   an_next;
   seg7_t               dec_seg;
   logic                dec_blank;

   seg7_t               seg_q;
   logic                dp_n_q;
   logic [DIGITS-1:0]   an_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
         idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_q <= '0;
         dp_q  <= '0;
         lzb_q <= 1'b0;
      end else if (bus.load) begin
         val_q <= bus.value_in;
         dp_q  <= bus.dp_in;
         lzb_q <= bus.lzb_in;
      end
   end

   // Walk down from the top digit; a digit is blank while all above it are zero.
   always_comb begin
      zero_run = 1'b1;
      lz_mask  = '0;
      for (int k = DIGITS - 1; k > 0; k--) begin
         zero_run   = zero_run && (val_q[4*k +: 4] == 4'd0);
         lz_mask[k] = lzb_q && zero_run;
      end
   end

   always_comb begin
      nib    = 4'd0;
      dp_cur = 1'b0;
      lz_cur = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx == IDX_W'(k)) begin
            nib    = val_q[4*k +: 4];
            dp_cur = dp_q[k];
            lz_cur = lz_mask[k];
         end
      end
   end

   always_comb begin
      an_on = (32'(cnt) < ON_CYCLES);
      for (int k = 0; k < DIGITS; k++) begin
         an_next[k] = !(an_on && (idx == IDX_W'(k)));
      end
   end

   seg7_decode u_decode (
      .nibble (nib),
      .seg    (dec_seg),
      .blank  (dec_blank)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q  <= SEG_BLANK;
         dp_n_q <= 1'b1;
         an_q   <= '1;
      end else begin
         if (lz_cur || dec_blank) begin
            seg_q  <= SEG_BLANK;
            dp_n_q <= 1'b1;
         end else begin
            seg_q  <= dec_seg;
            dp_n_q <= ~dp_cur;
         end
         an_q <= an_next;
      end
   end

   assign bus.seg  = seg_q;
   assign bus.dp_n = dp_n_q;
   assign bus.an   = an_q;
endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed driver for a bank of common-anode 7-segment digits. It holds a shadow register of packed BCD/hex nibbles loaded by a strobe, scans one digit per slot, and drives registered active-low segment, decimal-point and anode outputs. It sits between the counter/arithmetic datapath and the board display pins, and replaces per-digit combinational decoders with one shared decoder plus a scan sequencer.

## Interface
- DIGITS, 4: number of digits, legal 1..8
- SCAN_DIV, 50000: clock cycles per digit slot, legal >= 2
- GUARD, 16: cycles at the end of each slot with all anodes off (anti-ghosting), legal 0..SCAN_DIV-1
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  single-cycle strobe; captures value_in, dp_in, lzb_in
- value_in  in  4*DIGITS  packed nibbles, digit 0 = bits [3:0] (least significant)
- dp_in  in  DIGITS  decimal-point request per digit, 1 = lit
- lzb_in  in  1  leading-zero blanking enable
- seg  out  [0:6]  segments a..g, index 0 = a, active low
- dp_n  out  1  decimal point, active low
- an  out  DIGITS  digit enables, active low, at most one low

## Operation
- State: slot counter cnt (0..SCAN_DIV-1), digit index idx (0..DIGITS-1), shadow registers val_q, dp_q, lzb_q.
- cnt increments every cycle. At cnt = SCAN_DIV-1, cnt wraps to 0 and idx advances. At idx = DIGITS-1, idx wraps to 0.
- With DIGITS = 1, idx stays 0.
- Load: on a cycle with load = 1, the shadow registers take the inputs. Scan state is not disturbed. No busy signal; load is accepted on every cycle.
- Decode of the current nibble, active low a..g:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - 10..15: see Configuration
- Leading-zero blanking: when lzb_q = 1, digit k > 0 is blanked if it and every digit above it are 0. Digit 0 is never blanked.
- A blanked digit drives seg = 1111111 and dp_n = 1; its anode still follows the scan.
- dp_n = ~dp_q[idx] unless the digit is blanked.
- Anodes: an[idx] = 0 while cnt < SCAN_DIV-GUARD. All anodes are 1 otherwise. seg and dp_n still show the current digit during the guard window.

## Timing
- All outputs are registered from (cnt, idx, shadow), with a latency of 1 cycle.
- Reset values:
  - seg = 1111111, dp_n = 1, an = all 1
  - cnt = 0, idx = 0
  - val_q = 0, dp_q = 0, lzb_q = 0
- First edge after rst_n deasserts: an[0] = 0 and digit 0 is shown.
- A load sampled at edge N is visible on the outputs at edge N+1. This includes a load that lands mid-slot or inside the guard window.
- A load on the same cycle as a slot wrap: the new idx and the new data take effect together at the next output register update.
- Reset asserted mid-scan: all outputs go to their reset values immediately (asynchronously), and the shadow registers are cleared.
- Slot period is exactly SCAN_DIV cycles. Full frame is DIGITS*SCAN_DIV cycles.

## Configuration
- SEG7_HEX_EN defined: nibbles 10..15 render as A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000.
- SEG7_HEX_EN undefined: nibbles 10..15 render blank (1111111, dp_n = 1).
- The leading-zero test treats any nonzero nibble as significant in both builds.

## Structure
- Package seg7_pkg holds:
  - the SEG_BLANK constant
  - the per-digit pattern constants
  - the seg7_t typedef (logic [0:6])
  - the DIGITS legality limits
- Sub-module seg7_decode: combinational nibble -> seg7_t, honouring SEG7_HEX_EN. It is instantiated once, on the scanned nibble.
- Top level holds the counters, shadow registers, blanking logic and output registers.

## Test plan
- Reset release: DIGITS = 4, SCAN_DIV = 8, GUARD = 2.
  - During reset: an = 1111, seg = 1111111.
  - After rst_n rises: an = 1110 for 6 cycles, then 1111 for 2 cycles, then 1101.
- Load value_in = 16'h1234, dp_in = 4'b0100.
  - Expected slots: digit0 seg = 1001100; digit1 0000110; digit2 0010010 with dp_n = 0; digit3 1001111.
  - Frame repeats every 32 cycles.
- Load value_in = 16'h0070 with lzb_in = 1.
  - Digits 3 and 2 blank (1111111), digit1 0001111, digit0 0000001.
  - The same value with lzb_in = 0 shows 0000001 on digits 3 and 2.
- Load 16'h00AF.
  - With SEG7_HEX_EN: digit1 0001000, digit0 0111000.
  - Without it: both blank.
  - With lzb_in = 1: digits 3 and 2 blank in both builds.
- Load pulse at cnt = 7 (the wrap edge) with 16'h9999.
  - The next slot shows 0000100 and the scan phase is unchanged.
- Assert rst_n mid-slot: all outputs return to reset values without waiting for a clock edge.
